// File: rtl/tiny_dnn_seq.sv
// tiny_dnn_seq: loop sequencer for the tiny-dnn convolution engine.
// Walks o / y / x / c / ky / kx (outermost first) and issues one MAC command
// per kernel tap plus one output-write command per output pixel. Every
// address is built with adders from incrementally maintained bases.
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN      clock, async active-low reset
//   run                            level start; low aborts / acknowledges done
//   fs..ow                         layer configuration, captured at start
//   mac_valid/ready, mac_first/last, ia, wa   MAC command channel
//   out_valid/ready, oa            output-write command channel
//   busy, done                     sequence status
// Handshake: a command transfers on a cycle where valid and ready are both
// high; while valid is high and ready is low, the payload is held stable.
// mac_valid and out_valid are registered and never high together.
module tiny_dnn_seq #(
   parameter int AW = 12
) (
   input  logic          S_AXI_ACLK,
   input  logic          S_AXI_ARESETN,
   input  logic          run,
   input  logic [7:0]    fs,
   input  logic [2:0]    kh,
   input  logic [2:0]    kw,
   input  logic [11:0]   ss,
   input  logic [3:0]    id,
   input  logic [9:0]    is,
   input  logic [4:0]    ih,
   input  logic [4:0]    iw,
   input  logic [11:0]   ds,
   input  logic [3:0]    od,
   input  logic [9:0]    os,
   input  logic [4:0]    oh,
   input  logic [4:0]    ow,
   output logic          mac_valid,
   input  logic          mac_ready,
   output logic          mac_first,
   output logic          mac_last,
   output logic [AW-1:0] ia,
   output logic [AW-1:0] wa,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] oa,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT, S_DONE} state_t;

   typedef struct packed {
      logic [7:0]  fs;
      logic [2:0]  kh;
      logic [2:0]  kw;
      logic [11:0] ss;
      logic [3:0]  id;
      logic [9:0]  is;
      logic [11:0] ds;
      logic [3:0]  od;
      logic [9:0]  os;
      logic [4:0]  oh;
      logic [4:0]  ow;
   } cfg_t;

   // ih/iw are status-only inputs and take no part in addressing.
   logic cfg_unused;
   assign cfg_unused = ^{ih, iw};

   state_t        state_q, state_d;
   cfg_t          cfg_q, cfg_d;
   logic          run_s_q, run_s_d, run_p_q, run_p_d;
   logic [3:0]    o_q, o_d, c_q, c_d;
   logic [4:0]    y_q, y_d, x_q, x_d;
   logic [2:0]    ky_q, ky_d, kx_q, kx_d;
   // Input-side bases: ybase = y*is, pix = ybase + x, chan = pix + c*ss,
   // row = chan + ky*is. Output side: ob = o*ds, oyb = ob + y*os.
   logic [AW-1:0] ybase_q, ybase_d, pix_q, pix_d, chan_q, chan_d, row_q, row_d;
   logic [AW-1:0] ob_q, ob_d, oyb_q, oyb_d, wbase_q, wbase_d;
   logic [AW-1:0] ia_q, ia_d, wa_q, wa_d, oa_q, oa_d;
   logic          mac_valid_q, mac_valid_d, out_valid_q, out_valid_d;
   logic          mac_first_q, mac_first_d, mac_last_q, mac_last_d;
   logic          busy_q, busy_d, done_q, done_d;

   logic [AW-1:0] ss_a, is_a, ds_a, os_a, fs_a;
   assign ss_a = AW'(cfg_q.ss);
   assign is_a = AW'(cfg_q.is);
   assign ds_a = AW'(cfg_q.ds);
   assign os_a = AW'(cfg_q.os);
   assign fs_a = AW'(cfg_q.fs);

   // run is registered twice so the start edge is judged on two registered
   // samples; abort and done-acknowledge react to the live level.
   logic start;
   assign start = run_s_q && !run_p_q;

   always_comb begin
      state_d     = state_q;
      cfg_d       = cfg_q;
      run_s_d     = run;
      run_p_d     = run_s_q;
      o_d = o_q;  y_d = y_q;  x_d = x_q;
      c_d = c_q;  ky_d = ky_q;  kx_d = kx_q;
      ybase_d = ybase_q;  pix_d = pix_q;  chan_d = chan_q;  row_d = row_q;
      ob_d = ob_q;  oyb_d = oyb_q;  wbase_d = wbase_q;
      ia_d = ia_q;  wa_d = wa_q;  oa_d = oa_q;
      mac_valid_d = mac_valid_q;
      out_valid_d = out_valid_q;
      mac_first_d = mac_first_q;
      mac_last_d  = mac_last_q;
      busy_d      = busy_q;
      done_d      = done_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               cfg_d = '{fs: fs, kh: kh, kw: kw, ss: ss, id: id, is: is,
                         ds: ds, od: od, os: os, oh: oh, ow: ow};
               o_d = '0;  y_d = '0;  x_d = '0;  c_d = '0;  ky_d = '0;  kx_d = '0;
               ybase_d = '0;  pix_d = '0;  chan_d = '0;  row_d = '0;
               ob_d = '0;  oyb_d = '0;  wbase_d = '0;
               ia_d = '0;  wa_d = '0;  oa_d = '0;
               mac_valid_d = 1'b1;
               mac_first_d = 1'b1;
               mac_last_d  = (id == 4'd0) && (kh == 3'd0) && (kw == 3'd0);
               busy_d      = 1'b1;
               state_d     = S_MAC;
            end
         end
         S_MAC: begin
            if (!run) begin
               mac_valid_d = 1'b0;  mac_first_d = 1'b0;  mac_last_d = 1'b0;
               busy_d      = 1'b0;
               state_d     = S_IDLE;
            end else if (mac_ready) begin
               wa_d        = wa_q + 1'b1;
               mac_first_d = 1'b0;
               if (mac_last_q) begin
                  mac_valid_d = 1'b0;
                  mac_last_d  = 1'b0;
                  out_valid_d = 1'b1;
                  state_d     = S_OUT;
               end else begin
                  if (kx_q != cfg_q.kw) begin
                     kx_d = kx_q + 1'b1;
                     ia_d = ia_q + 1'b1;
                  end else begin
                     kx_d = '0;
                     if (ky_q != cfg_q.kh) begin
                        ky_d  = ky_q + 1'b1;
                        row_d = row_q + is_a;
                        ia_d  = row_q + is_a;
                     end else begin
                        // Not mac_last, so c is below id here.
                        ky_d   = '0;
                        c_d    = c_q + 1'b1;
                        chan_d = chan_q + ss_a;
                        row_d  = chan_q + ss_a;
                        ia_d   = chan_q + ss_a;
                     end
                  end
                  mac_last_d = (c_d == cfg_q.id) && (ky_d == cfg_q.kh) && (kx_d == cfg_q.kw);
               end
            end
         end
         S_OUT: begin
            if (!run) begin
               out_valid_d = 1'b0;
               busy_d      = 1'b0;
               state_d     = S_IDLE;
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               if ((x_q == cfg_q.ow) && (y_q == cfg_q.oh) && (o_q == cfg_q.od)) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  wa_d = wbase_q;
                  if (x_q != cfg_q.ow) begin
                     x_d   = x_q + 1'b1;
                     pix_d = pix_q + 1'b1;
                     oa_d  = oa_q + 1'b1;
                  end else begin
                     x_d = '0;
                     if (y_q != cfg_q.oh) begin
                        y_d     = y_q + 1'b1;
                        ybase_d = ybase_q + is_a;
                        pix_d   = ybase_q + is_a;
                        oyb_d   = oyb_q + os_a;
                        oa_d    = oyb_q + os_a;
                     end else begin
                        y_d     = '0;
                        o_d     = o_q + 1'b1;
                        ybase_d = '0;
                        pix_d   = '0;
                        ob_d    = ob_q + ds_a;
                        oyb_d   = ob_q + ds_a;
                        oa_d    = ob_q + ds_a;
                        wbase_d = wbase_q + fs_a;
                        wa_d    = wbase_q + fs_a;
                     end
                  end
                  // New pixel: every input base restarts at the pixel origin.
                  c_d = '0;  ky_d = '0;  kx_d = '0;
                  chan_d = pix_d;  row_d = pix_d;  ia_d = pix_d;
                  mac_valid_d = 1'b1;
                  mac_first_d = 1'b1;
                  mac_last_d  = (cfg_q.id == 4'd0) && (cfg_q.kh == 3'd0) && (cfg_q.kw == 3'd0);
                  state_d     = S_MAC;
               end
            end
         end
         S_DONE: begin
            if (!run) begin
               done_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         state_q <= S_IDLE;
         cfg_q   <= '0;
         run_s_q <= 1'b0;  run_p_q <= 1'b0;
         o_q <= '0;  y_q <= '0;  x_q <= '0;  c_q <= '0;  ky_q <= '0;  kx_q <= '0;
         ybase_q <= '0;  pix_q <= '0;  chan_q <= '0;  row_q <= '0;
         ob_q <= '0;  oyb_q <= '0;  wbase_q <= '0;
         ia_q <= '0;  wa_q <= '0;  oa_q <= '0;
         mac_valid_q <= 1'b0;  out_valid_q <= 1'b0;
         mac_first_q <= 1'b0;  mac_last_q  <= 1'b0;
         busy_q <= 1'b0;  done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cfg_q   <= cfg_d;
         run_s_q <= run_s_d;  run_p_q <= run_p_d;
         o_q <= o_d;  y_q <= y_d;  x_q <= x_d;  c_q <= c_d;  ky_q <= ky_d;  kx_q <= kx_d;
         ybase_q <= ybase_d;  pix_q <= pix_d;  chan_q <= chan_d;  row_q <= row_d;
         ob_q <= ob_d;  oyb_q <= oyb_d;  wbase_q <= wbase_d;
         ia_q <= ia_d;  wa_q <= wa_d;  oa_q <= oa_d;
         mac_valid_q <= mac_valid_d;  out_valid_q <= out_valid_d;
         mac_first_q <= mac_first_d;  mac_last_q  <= mac_last_d;
         busy_q <= busy_d;  done_q <= done_d;
      end
   end

   assign mac_valid = mac_valid_q;
   assign out_valid = out_valid_q;
   assign mac_first = mac_first_q;
   assign mac_last  = mac_last_q;
   assign ia        = ia_q;
   assign wa        = wa_q;
   assign oa        = oa_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_tiny_dnn_seq.sv
// Bench for tiny_dnn_seq: a loop-nest reference model builds the expected
// MAC and write command streams; a compare process checks every presented
// command against the head of those queues.
module tb_tiny_dnn_seq;
   localparam int AW = 12;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          run = 1'b0;
   logic [7:0]    cfg_fs = '0;
   logic [2:0]    cfg_kh = '0, cfg_kw = '0;
   logic [11:0]   cfg_ss = '0, cfg_ds = '0;
   logic [3:0]    cfg_id = '0, cfg_od = '0;
   logic [9:0]    cfg_is = '0, cfg_os = '0;
   logic [4:0]    cfg_ih = '0, cfg_iw = '0, cfg_oh = '0, cfg_ow = '0;
   logic          mac_valid, mac_ready = 1'b1, mac_first, mac_last;
   logic [AW-1:0] ia, wa, oa;
   logic          out_valid, out_ready = 1'b1, busy, done;

   int  n_checks = 0;
   int  n_errors = 0;
   bit  chk_en = 1'b0;
   bit  stall = 1'b0;

   logic [2*AW+1:0] exp_mac_q[$];
   logic [AW-1:0]   exp_oa_q[$];
   logic [AW-1:0]   ia_log[$], wa_log[$], oa_log[$];

   tiny_dnn_seq #(.AW(AW)) dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .run(run),
      .fs(cfg_fs), .kh(cfg_kh), .kw(cfg_kw), .ss(cfg_ss), .id(cfg_id),
      .is(cfg_is), .ih(cfg_ih), .iw(cfg_iw), .ds(cfg_ds), .od(cfg_od),
      .os(cfg_os), .oh(cfg_oh), .ow(cfg_ow),
      .mac_valid(mac_valid), .mac_ready(mac_ready), .mac_first(mac_first),
      .mac_last(mac_last), .ia(ia), .wa(wa),
      .out_valid(out_valid), .out_ready(out_ready), .oa(oa),
      .busy(busy), .done(done)
   );

   // ---------------- clock / reset ----------------
   initial forever #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
      $fatal(1, "timeout");
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_log(input string name, input logic [AW-1:0] q[$],
                            input int n, input int e[8]);
      check({name, "_count"}, q.size(), n);
      for (int i = 0; i < n; i++)
         if (i < q.size()) check(name, q[i], e[i]);
   endtask

   task automatic set_cfg(input int fs_v, input int kh_v, input int kw_v, input int ss_v,
                          input int id_v, input int is_v, input int ds_v, input int od_v,
                          input int os_v, input int oh_v, input int ow_v);
      cfg_fs = 8'(fs_v);  cfg_kh = 3'(kh_v);  cfg_kw = 3'(kw_v);  cfg_ss = 12'(ss_v);
      cfg_id = 4'(id_v);  cfg_is = 10'(is_v); cfg_ds = 12'(ds_v); cfg_od = 4'(od_v);
      cfg_os = 10'(os_v); cfg_oh = 5'(oh_v);  cfg_ow = 5'(ow_v);
      cfg_ih = 5'($urandom_range(0, 31));  cfg_iw = 5'($urandom_range(0, 31));
   endtask

   // Reference model: the plain loop nest with multiplications.
   task automatic build_model();
      int taps, t, a, w, o_a;
      exp_mac_q.delete();  exp_oa_q.delete();
      ia_log.delete();  wa_log.delete();  oa_log.delete();
      taps = (int'(cfg_id) + 1) * (int'(cfg_kh) + 1) * (int'(cfg_kw) + 1);
      for (int o = 0; o <= int'(cfg_od); o++)
         for (int y = 0; y <= int'(cfg_oh); y++)
            for (int x = 0; x <= int'(cfg_ow); x++) begin
               t = 0;
               for (int c = 0; c <= int'(cfg_id); c++)
                  for (int ky = 0; ky <= int'(cfg_kh); ky++)
                     for (int kx = 0; kx <= int'(cfg_kw); kx++) begin
                        a = c * int'(cfg_ss) + (y + ky) * int'(cfg_is) + (x + kx);
                        w = o * int'(cfg_fs) + t;
                        exp_mac_q.push_back({(t == 0), (t == taps - 1), a[AW-1:0], w[AW-1:0]});
                        t++;
                     end
               o_a = o * int'(cfg_ds) + y * int'(cfg_os) + x;
               exp_oa_q.push_back(o_a[AW-1:0]);
            end
   endtask

   // ---------------- ready driver ----------------
   initial forever begin
      @(posedge clk);
      #1;
      mac_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // ---------------- scoreboard / compare ----------------
   initial forever begin
      @(negedge clk);
      if (chk_en && rst_n) begin
         check("valid_exclusive", mac_valid & out_valid, 1'b0);
         if (mac_valid) begin
            check("busy_during_mac", busy, 1'b1);
            if (exp_mac_q.size() == 0) check("mac_unexpected", 1, 0);
            else begin
               check("mac_cmd", {mac_first, mac_last, ia, wa}, exp_mac_q[0]);
               if (mac_ready) begin
                  void'(exp_mac_q.pop_front());
                  ia_log.push_back(ia);  wa_log.push_back(wa);
               end
            end
         end
         if (out_valid) begin
            check("busy_during_out", busy, 1'b1);
            if (exp_oa_q.size() == 0) check("out_unexpected", 1, 0);
            else begin
               check("out_oa", oa, exp_oa_q[0]);
               if (out_ready) begin
                  void'(exp_oa_q.pop_front());
                  oa_log.push_back(oa);
               end
            end
         end
      end
   end

   // One full sequence: start latency, streams via the scoreboard, done handling.
   task automatic run_seq(input bit stalls);
      int cycles;
      build_model();
      stall = stalls;
      chk_en = 1'b1;
      @(posedge clk);
      #1 run = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("start_latency_early", mac_valid, 1'b0);
      @(negedge clk);
      check("start_mac_valid", mac_valid, 1'b1);
      check("start_busy", busy, 1'b1);
      // Configuration is shadowed; scrambling the inputs must have no effect.
      set_cfg($urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom, $urandom);
      cycles = 0;
      while (!done && cycles < 20000) begin
         @(negedge clk);
         cycles++;
      end
      check("done_reached", done, 1'b1);
      check("done_busy", busy, 1'b0);
      check("mac_left", exp_mac_q.size(), 0);
      check("out_left", exp_oa_q.size(), 0);
      repeat (3) @(negedge clk);
      check("done_held", done, 1'b1);
      check("no_restart_while_high", mac_valid, 1'b0);
      run = 1'b0;
      @(negedge clk);
      check("done_cleared", done, 1'b0);
      chk_en = 1'b0;
      stall = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n, cycles;
      // Reset state
      @(negedge clk);
      check("reset_mac_valid", mac_valid, 1'b0);
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_first_last", {mac_first, mac_last}, 2'b00);
      check("reset_addr", {ia, wa, oa}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // All sizes zero: one MAC, one write.
      set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      build_model();
      check("model_zero_count", exp_mac_q.size(), 1);
      check("model_zero_cmd", exp_mac_q[0], {1'b1, 1'b1, 12'd0, 12'd0});
      run_seq(1'b0);
      check_log("zero_oa", oa_log, 1, '{0, 0, 0, 0, 0, 0, 0, 0});

      // 2x2 kernel, single channel.
      set_cfg(4, 1, 1, 0, 0, 4, 0, 0, 0, 0, 0);
      run_seq(1'b0);
      check_log("k2_ia", ia_log, 4, '{0, 1, 4, 5, 0, 0, 0, 0});
      check_log("k2_wa", wa_log, 4, '{0, 1, 2, 3, 0, 0, 0, 0});
      check_log("k2_oa", oa_log, 1, '{0, 0, 0, 0, 0, 0, 0, 0});

      // Two input channels, two output channels.
      set_cfg(2, 0, 0, 16, 1, 0, 8, 1, 0, 0, 0);
      run_seq(1'b0);
      check_log("ch_ia", ia_log, 4, '{0, 16, 0, 16, 0, 0, 0, 0});
      check_log("ch_wa", wa_log, 4, '{0, 1, 2, 3, 0, 0, 0, 0});
      check_log("ch_oa", oa_log, 2, '{0, 8, 0, 0, 0, 0, 0, 0});

      // 2x2 output, 1x1 kernel, random stalls.
      set_cfg(0, 0, 0, 0, 0, 3, 0, 0, 2, 1, 1);
      run_seq(1'b1);
      check_log("px_ia", ia_log, 4, '{0, 1, 3, 4, 0, 0, 0, 0});
      check_log("px_oa", oa_log, 4, '{0, 1, 2, 3, 0, 0, 0, 0});

      // Random configurations (large strides exercise address wrap).
      for (int r = 0; r < 8; r++) begin
         set_cfg($urandom_range(0, 255), $urandom_range(0, 2), $urandom_range(0, 2),
                 $urandom_range(0, 4095), $urandom_range(0, 2), $urandom_range(0, 1023),
                 $urandom_range(0, 4095), $urandom_range(0, 2), $urandom_range(0, 1023),
                 $urandom_range(0, 2), $urandom_range(0, 2));
         run_seq(r[0]);
      end

      // Abort during the third MAC.
      set_cfg(4, 1, 1, 0, 0, 4, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1 run = 1'b1;
      n = 0;
      cycles = 0;
      while (n < 3 && cycles < 50) begin
         @(negedge clk);
         cycles++;
         if (mac_valid) n++;
      end
      check("abort_reached_mac3", n, 3);
      check("abort_mac3_ia", ia, 12'd4);
      run = 1'b0;
      @(negedge clk);
      check("abort_mac_valid", mac_valid, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_out_valid", out_valid, 1'b0);
      repeat (4) @(negedge clk);
      check("abort_no_done", done, 1'b0);
      run_seq(1'b0);

      // Asynchronous reset while a write is pending.
      set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      @(posedge clk);
      #1 run = 1'b1;
      cycles = 0;
      while (!(out_valid && oa == 12'd1) && cycles < 50) begin
         @(negedge clk);
         cycles++;
      end
      check("rst_reached_out", {out_valid, oa}, {1'b1, 12'd1});
      run = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_async_valids", {mac_valid, out_valid}, 2'b00);
      check("rst_async_status", {busy, done, mac_first, mac_last}, 4'b0000);
      check("rst_async_addr", {ia, wa, oa}, '0);
      #20 rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_idle_after", {mac_valid, out_valid, busy, done}, 4'b0000);
      run_seq(1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
